// File: rtl/lm32_logic_arbiter_pkg.sv
// Shared widths, truth-table opcodes, lock FSM states and the
// bitwise truth-table logic function used by the logic arbiter.
package lm32_logic_arbiter_pkg;

  localparam int LM32_LOGIC_OP_W = 4;
  localparam int LM32_WORD_W     = 32;

  typedef logic [LM32_LOGIC_OP_W-1:0] lm32_op_t;
  typedef logic [LM32_WORD_W-1:0]     lm32_word_t;

  localparam lm32_op_t LM32_OP_AND   = 4'b1000;
  localparam lm32_op_t LM32_OP_OR    = 4'b1110;
  localparam lm32_op_t LM32_OP_XOR   = 4'b0110;
  localparam lm32_op_t LM32_OP_NOR   = 4'b0001;
  localparam lm32_op_t LM32_OP_PASS0 = 4'b1010;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    lm32_op_t   op;
    lm32_word_t opnd0;
    lm32_word_t opnd1;
  } s1_t;

  // result[b] = op[{operand_1[b], operand_0[b]}]
  function automatic lm32_word_t lm32_logic_op(
    input lm32_op_t   op,
    input lm32_word_t a0,
    input lm32_word_t a1
  );
    lm32_word_t r;
    for (int b = 0; b < LM32_WORD_W; b++) begin
      r[b] = op[{a1[b], a0[b]}];
    end
    return r;
  endfunction

endpackage

// File: rtl/lm32_logic_arbiter_rr.sv
// Round-robin arbiter: first masked request at or above ptr_i, wrapping.
// Ports: req_i, ptr_i, mask_i in; gnt_o (one-hot), gnt_id_o, gnt_valid_o out.
module lm32_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               gnt_valid_o
);

  logic [NUM_REQ-1:0]   req_m;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W:0]        sum;

  assign req_m = req_i & mask_i;
  // Rotate so bit 0 is the requester at ptr_i.
  assign dbl   = {req_m, req_m} >> ptr_i;
  assign rot   = dbl[NUM_REQ-1:0];

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    sum         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_valid_o && rot[k]) begin
        gnt_valid_o = 1'b1;
        sum = {1'b0, ptr_i} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
          sum = sum - (ID_W+1)'(NUM_REQ);
        end
        gnt_id_o = sum[ID_W-1:0];
      end
    end
    gnt_o = gnt_valid_o ? (NUM_REQ'(1) << gnt_id_o) : '0;
  end

endmodule

// File: rtl/lm32_logic_arbiter.sv
// Round-robin shared truth-table logic unit with a 2-stage result pipeline.
// Ports: clk_i, rst_n_i, flush_i; per-requester req_valid_i/req_ready_o,
// req_op_i, req_operand_0_i/1_i, req_lock_i; result res_valid_o/res_ready_i,
// res_data_o, res_id_o. Macro LM32_LOGIC_ARB_LOCK_EN enables grant locking.
// req_ready_o depends combinationally on res_ready_i.
module lm32_logic_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [4*NUM_REQ-1:0]  req_op_i,
  input  logic [32*NUM_REQ-1:0] req_operand_0_i,
  input  logic [32*NUM_REQ-1:0] req_operand_1_i,
  input  logic [NUM_REQ-1:0]    req_lock_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [31:0]           res_data_o,
  output logic [ID_W-1:0]       res_id_o
);

  import lm32_logic_arbiter_pkg::*;

  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] mask;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               adv1;
  logic               adv2;
  logic               take;

  logic               s1_valid_q, s1_valid_d;
  s1_t                s1_q, s1_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic               res_valid_q, res_valid_d;
  lm32_word_t         res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  lm32_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .mask_i      (mask),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  assign adv2 = !res_valid_q | res_ready_i;
  assign adv1 = !s1_valid_q | adv2;
  // rst_n_i gate keeps ready low while reset is held.
  assign take = gnt_valid & adv1 & !flush_i & rst_n_i;
  assign req_ready_o = gnt & {NUM_REQ{take}};

`ifdef LM32_LOGIC_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  lock_state_e        lock_st_q, lock_st_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_st_q <= ST_UNLOCKED;
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      lock_st_q <= lock_st_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    lock_st_d = lock_st_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      lock_st_d = ST_UNLOCKED;
      cnt_d     = '0;
    end else if (take) begin
      unique case (lock_st_q)
        ST_UNLOCKED: begin
          if (req_lock_i[gnt_id]) begin
            lock_st_d = ST_LOCKED;
            owner_d   = gnt_id;
            cnt_d     = CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!req_lock_i[gnt_id] ||
              cnt_q == CNT_W'(LOCK_MAX-1)) begin
            lock_st_d = ST_UNLOCKED;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: lock_st_d = ST_UNLOCKED;
      endcase
    end
  end

  // While locked, only the owner can win, even when it is idle.
  always_comb begin
    mask = '1;
    if (lock_st_q == ST_LOCKED) begin
      mask = NUM_REQ'(1) << owner_q;
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^req_lock_i ^ LOCK_MAX[0];
  assign mask = '1;
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s1_id_d     = s1_id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (adv2) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_data_d = lm32_logic_op(s1_q.op, s1_q.opnd0,
                                   s1_q.opnd1);
        res_id_d   = s1_id_q;
      end
    end
    if (adv1) begin
      s1_valid_d = 1'b0;
    end
    if (take) begin
      s1_valid_d = 1'b1;
      s1_d.op    = req_op_i[{gnt_id, 2'b00} +: 4];
      s1_d.opnd0 = req_operand_0_i[{gnt_id, 5'b0} +: 32];
      s1_d.opnd1 = req_operand_1_i[{gnt_id, 5'b0} +: 32];
      s1_id_d    = gnt_id;
      rr_ptr_d   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0
                   : gnt_id + ID_W'(1);
    end
    if (flush_i) begin
      s1_valid_d  = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_id_o    = res_id_q;

endmodule
